pe_loop_sequencer: RTL and testbench

PE_LOOP_SEQUENCER -- requirements
Module: pe_loop_sequencer

---
 rtl/pe_loop_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pe_loop_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_loop_sequencer.sv
// Four-deep loop sequencer (w > pm > tch > s) producing input/weight/psum pad read addresses.
// Optional stall-cycle counter is built when LOOPSEQ_PERF_EN is defined.
module pe_loop_sequencer #(
    parameter int CNT_WD  = 4,
    parameter int TILE_WD = 6,
    parameter int IPAD_AW = 6,
    parameter int WPAD_AW = 8,
    parameter int PPAD_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_stall,
    input  logic [TILE_WD-1:0] i_w,
    input  logic [CNT_WD-1:0]  i_pm,
    input  logic [CNT_WD-1:0]  i_tch,
    input  logic [CNT_WD-1:0]  i_s,
    output logic               o_valid,
    output logic [IPAD_AW-1:0] o_ip_addr,
    output logic [WPAD_AW-1:0] o_wp_addr,
    output logic [PPAD_AW-1:0] o_pp_addr,
    output logic               o_first,
    output logic               o_last,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [15:0]        o_stall_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [TILE_WD-1:0] w_cnt_q, w_cnt_d, w_q, w_d;
    logic [CNT_WD-1:0]  pm_cnt_q, pm_cnt_d, pm_q, pm_d;
    logic [CNT_WD-1:0]  tch_cnt_q, tch_cnt_d, tch_q, tch_d;
    logic [CNT_WD-1:0]  s_cnt_q, s_cnt_d, s_q, s_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic s_wrap, tch_wrap, pm_wrap, w_wrap, cfg_zero, valid;

    assign s_wrap   = (s_q   == s_cnt_q   - CNT_WD'(1));
    assign tch_wrap = (tch_q == tch_cnt_q - CNT_WD'(1));
    assign pm_wrap  = (pm_q  == pm_cnt_q  - CNT_WD'(1));
    assign w_wrap   = (w_q   == w_cnt_q   - TILE_WD'(1));
    assign cfg_zero = (w_cnt_q == '0) || (pm_cnt_q == '0) || (tch_cnt_q == '0) || (s_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        w_cnt_d   = w_cnt_q;
        pm_cnt_d  = pm_cnt_q;
        tch_cnt_d = tch_cnt_q;
        s_cnt_d   = s_cnt_q;
        w_d       = w_q;
        pm_d      = pm_q;
        tch_d     = tch_q;
        s_d       = s_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = LOAD;
                    w_cnt_d   = i_w;
                    pm_cnt_d  = i_pm;
                    tch_cnt_d = i_tch;
                    s_cnt_d   = i_s;
                end
            end
            LOAD: begin
                w_d   = '0;
                pm_d  = '0;
                tch_d = '0;
                s_d   = '0;
                if (i_abort) begin
                    state_d = IDLE;
                end else if (cfg_zero) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (i_abort) begin
                    // Indices are cleared so addresses read 0 while idle after an abort.
                    state_d = IDLE;
                    w_d     = '0;
                    pm_d    = '0;
                    tch_d   = '0;
                    s_d     = '0;
                end else if (!i_stall) begin
                    s_d = s_wrap ? '0 : s_q + CNT_WD'(1);
                    if (s_wrap) begin
                        tch_d = tch_wrap ? '0 : tch_q + CNT_WD'(1);
                        if (tch_wrap) begin
                            pm_d = pm_wrap ? '0 : pm_q + CNT_WD'(1);
                            if (pm_wrap) begin
                                w_d = w_wrap ? '0 : w_q + TILE_WD'(1);
                                if (w_wrap) begin
                                    state_d = DONE;
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == LOAD) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            w_cnt_q   <= '0;
            pm_cnt_q  <= '0;
            tch_cnt_q <= '0;
            s_cnt_q   <= '0;
            w_q       <= '0;
            pm_q      <= '0;
            tch_q     <= '0;
            s_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_cnt_q   <= w_cnt_d;
            pm_cnt_q  <= pm_cnt_d;
            tch_cnt_q <= tch_cnt_d;
            s_cnt_q   <= s_cnt_d;
            w_q       <= w_d;
            pm_q      <= pm_d;
            tch_q     <= tch_d;
            s_q       <= s_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Outputs are forced low while rst is high so the reset cycle itself is quiet.
    assign valid     = (state_q == RUN) && !i_stall && !rst;
    assign o_valid   = valid;
    assign o_first   = valid && (tch_q == '0) && (s_q == '0);
    assign o_last    = valid && tch_wrap && s_wrap;
    assign o_busy    = busy_q && !rst;
    assign o_done    = done_q && !rst;
    assign o_error   = err_q && !rst;
    assign o_ip_addr = rst ? '0 :
        IPAD_AW'((32'(w_q) + 32'(s_q)) * 32'(tch_cnt_q) + 32'(tch_q));
    assign o_wp_addr = rst ? '0 :
        WPAD_AW'((32'(pm_q) * 32'(tch_cnt_q) + 32'(tch_q)) * 32'(s_cnt_q) + 32'(s_q));
    assign o_pp_addr = rst ? '0 : PPAD_AW'(pm_q);

`ifdef LOOPSEQ_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && i_start) begin
            stall_cnt_d = '0;
        end else if (state_q == RUN && i_stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = rst ? '0 : stall_cnt_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Directed bench for pe_loop_sequencer: table of job configurations plus hand-written
// sequences for stall, abort, illegal configuration and mid-run reset.
module tb_pe_loop_sequencer;

    logic        clk;
    logic        rst;
    logic        i_start, i_abort, i_stall;
    logic [5:0]  i_w;
    logic [3:0]  i_pm, i_tch, i_s;
    logic        o_valid, o_first, o_last, o_busy, o_done, o_error;
    logic [5:0]  o_ip_addr;
    logic [7:0]  o_wp_addr;
    logic [3:0]  o_pp_addr;
    logic [15:0] o_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pe_loop_sequencer dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_stall(i_stall),
        .i_w(i_w), .i_pm(i_pm), .i_tch(i_tch), .i_s(i_s),
        .o_valid(o_valid), .o_ip_addr(o_ip_addr), .o_wp_addr(o_wp_addr), .o_pp_addr(o_pp_addr),
        .o_first(o_first), .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_stall_cnt(o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] w;
        logic [3:0] pm, tch, s;
        int         beats;
        int         fl;
        logic [5:0] ip;
        logic [7:0] wp;
        logic [3:0] pp;
        logic       err;
    } vec_t;

    typedef struct {
        int         beats, firsts, lasts;
        int         first_at, last_at, done_at, err_at;
        logic [5:0] last_ip;
        logic [7:0] last_wp;
        logic [3:0] last_pp;
    } res_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Start a job, scramble the count inputs afterwards, and watch until done/error.
    task automatic run_job(input logic [5:0] w, input logic [3:0] pm, input logic [3:0] tch,
                           input logic [3:0] s, input int limit, output res_t r);
        r = '{beats: 0, firsts: 0, lasts: 0, first_at: -1, last_at: -1, done_at: -1,
              err_at: -1, last_ip: '0, last_wp: '0, last_pp: '0};
        i_w = w; i_pm = pm; i_tch = tch; i_s = s; i_start = 1'b1;
        cyc();
        i_start = 1'b0; i_w = '0; i_pm = '0; i_tch = '0; i_s = '0;
        for (int c = 1; c <= limit; c++) begin
            #1;
            if (o_valid) begin
                if (r.beats == 0) r.first_at = c;
                r.beats++;
                if (o_first) r.firsts++;
                if (o_last) r.lasts++;
                r.last_ip = o_ip_addr; r.last_wp = o_wp_addr; r.last_pp = o_pp_addr;
                r.last_at = c;
            end
            if (o_error && r.err_at < 0) r.err_at = c;
            if (o_done) r.done_at = c;
            cyc();
            if (r.done_at >= 0 || r.err_at >= 0) break;
        end
    endtask

    initial begin
        res_t        r;
        int          nb, last_at, done_at;
        logic [11:0] fm, lm;
        logic [5:0]  ipseq[12];
        logic [5:0]  exp_ip[12];
        logic [4:0]  vpat;
        logic        any_v, any_d, any_b;

        exp_ip = '{6'd0, 6'd2, 6'd4, 6'd1, 6'd3, 6'd5, 6'd2, 6'd4, 6'd6, 6'd3, 6'd5, 6'd7};
        //            w   pm  tch  s   beats fl  ip   wp     pp  err
        vecs[0] = '{6'd2,  4'd1,  4'd2,  4'd3,  12,   2, 6'd7,  8'd5,  4'd0,  1'b0};
        vecs[1] = '{6'd1,  4'd1,  4'd1,  4'd1,   1,   1, 6'd0,  8'd0,  4'd0,  1'b0};
        vecs[2] = '{6'd3,  4'd2,  4'd1,  4'd1,   6,   6, 6'd2,  8'd1,  4'd1,  1'b0};
        vecs[3] = '{6'd1,  4'd2,  4'd3,  4'd2,  12,   2, 6'd5,  8'd11, 4'd1,  1'b0};
        vecs[4] = '{6'd2,  4'd3,  4'd2,  4'd2,  24,   6, 6'd5,  8'd11, 4'd2,  1'b0};
        vecs[5] = '{6'd4,  4'd1,  4'd1,  4'd4,  16,   4, 6'd6,  8'd3,  4'd0,  1'b0};
        vecs[6] = '{6'd1,  4'd1,  4'd0,  4'd1,   0,   0, 6'd0,  8'd0,  4'd0,  1'b1};
        vecs[7] = '{6'd1,  4'd15, 4'd15, 4'd15, 3375, 15, 6'd32, 8'd46, 4'd14, 1'b0};
        vecs[8] = '{6'd63, 4'd1,  4'd1,  4'd1,  63,  63, 6'd62, 8'd0,  4'd0,  1'b0};

        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_stall = 1'b0;
        i_w = 6'd1; i_pm = 4'd1; i_tch = 4'd1; i_s = 4'd1;
        cyc(); cyc();
        chk("reset_outputs_during", {o_valid, o_first, o_last, o_busy, o_done, o_error},  6'd0);
        chk("reset_addr_during", {o_ip_addr, o_wp_addr, o_pp_addr, o_stall_cnt}, 34'd0);
        rst = 1'b0;
        cyc();
        chk("reset_outputs_after", {o_valid, o_first, o_last, o_busy, o_done, o_error}, 6'd0);
        chk("reset_addr_after", {o_ip_addr, o_wp_addr, o_pp_addr, o_stall_cnt}, 34'd0);

        for (int i = 0; i < 9; i++) begin
            run_job(vecs[i].w, vecs[i].pm, vecs[i].tch, vecs[i].s, vecs[i].beats + 10, r);
            chk($sformatf("row%0d_beats", i), r.beats, vecs[i].beats);
            if (vecs[i].err) begin
                chk($sformatf("row%0d_err_at", i), r.err_at, 2);
                chk($sformatf("row%0d_no_done", i), r.done_at, -1);
                #1;
                chk($sformatf("row%0d_err_single", i), {o_error, o_busy}, 2'b00);
            end else begin
                chk($sformatf("row%0d_firsts", i), r.firsts, vecs[i].fl);
                chk($sformatf("row%0d_lasts", i), r.lasts, vecs[i].fl);
                chk($sformatf("row%0d_last_ip", i), r.last_ip, vecs[i].ip);
                chk($sformatf("row%0d_last_wp", i), r.last_wp, vecs[i].wp);
                chk($sformatf("row%0d_last_pp", i), r.last_pp, vecs[i].pp);
                chk($sformatf("row%0d_latency", i), r.first_at, 2);
                chk($sformatf("row%0d_done_at", i), r.done_at, r.last_at + 1);
                chk($sformatf("row%0d_no_err", i), r.err_at, -1);
            end
            cyc();
        end

        // W=2 PM=1 TCH=2 S=3 with a stray start pulse and changed counts mid-run.
        i_w = 6'd2; i_pm = 4'd1; i_tch = 4'd2; i_s = 4'd3; i_start = 1'b1;
        cyc();
        i_start = 1'b0; i_w = 6'd5; i_s = 4'd0;
        nb = 0; fm = '0; lm = '0; last_at = -1; done_at = -1;
        for (int c = 1; c < 40 && done_at < 0; c++) begin
            i_start = (nb == 3);
            #1;
            if (o_valid) begin
                if (nb < 12) begin
                    ipseq[nb] = o_ip_addr;
                    fm[nb] = o_first;
                    lm[nb] = o_last;
                end
                last_at = c;
                nb++;
            end
            if (o_done) done_at = c;
            cyc();
        end
        i_start = 1'b0;
        #1;
        chk("seq_beats", nb, 12);
        for (int k = 0; k < 12; k++) chk($sformatf("seq_ip%0d", k), ipseq[k], exp_ip[k]);
        chk("seq_first_mask", fm, 12'h041);
        chk("seq_last_mask", lm, 12'h820);
        chk("seq_done_at", done_at, last_at + 1);
        chk("seq_done_single", {o_done, o_busy}, 2'b00);
        cyc();

        // Stall for three cycles after the first beat of W=1 PM=2 TCH=1 S=1.
        i_w = 6'd1; i_pm = 4'd2; i_tch = 4'd1; i_s = 4'd1; i_start = 1'b1;
        cyc();
        i_start = 1'b0; i_stall = 1'b1;
        #1;
        chk("stall_load_busy", {o_busy, o_valid}, 2'b10);
        cyc();
        i_stall = 1'b0;
        #1;
        vpat[4] = o_valid;
        chk("stall_beat0_pp", o_pp_addr, 4'd0);
        chk("stall_beat0_fl", {o_first, o_last}, 2'b11);
        cyc();
        for (int k = 0; k < 3; k++) begin
            i_stall = 1'b1;
            #1;
            vpat[3-k] = o_valid;
            chk($sformatf("stall_hold_pp%0d", k), o_pp_addr, 4'd1);
            cyc();
        end
        i_stall = 1'b0;
        #1;
        vpat[0] = o_valid;
        chk("stall_valid_pattern", vpat, 5'b10001);
        chk("stall_beat1_pp", o_pp_addr, 4'd1);
        cyc();
        #1;
        chk("stall_done", o_done, 1'b1);
`ifdef LOOPSEQ_PERF_EN
        chk("stall_cnt_done", o_stall_cnt, 16'd3);
`else
        chk("stall_cnt_done", o_stall_cnt, 16'd0);
`endif
        cyc();
`ifdef LOOPSEQ_PERF_EN
        chk("stall_cnt_idle", o_stall_cnt, 16'd3);
`else
        chk("stall_cnt_idle", o_stall_cnt, 16'd0);
`endif
        chk("stall_idle_busy", o_busy, 1'b0);

        // Abort on beat 4 of the 12-beat job.
        i_w = 6'd2; i_pm = 4'd1; i_tch = 4'd2; i_s = 4'd3; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        nb = 0;
        for (int c = 1; c < 20 && nb < 5; c++) begin
            i_abort = (nb == 4);
            #1;
            if (o_valid) nb++;
            cyc();
        end
        i_abort = 1'b0;
        chk("abort_beats_before", nb, 5);
        any_v = 1'b0; any_d = 1'b0; any_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            any_v |= o_valid; any_d |= o_done; any_b |= o_busy;
            cyc();
        end
        chk("abort_no_valid", any_v, 1'b0);
        chk("abort_no_done", any_d, 1'b0);
        chk("abort_not_busy", any_b, 1'b0);
        run_job(6'd1, 4'd1, 4'd1, 4'd1, 10, r);
        chk("after_abort_beats", r.beats, 1);
        chk("after_abort_first", r.firsts, 1);
        chk("after_abort_last", r.lasts, 1);
        cyc();

        // Abort wins over stall.
        i_w = 6'd2; i_pm = 4'd1; i_tch = 4'd2; i_s = 4'd3; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        cyc();
        i_stall = 1'b1; i_abort = 1'b1;
        cyc();
        i_stall = 1'b0; i_abort = 1'b0;
        #1;
        chk("abort_stall_idle", {o_busy, o_valid}, 2'b00);
        cyc(); cyc();
        chk("abort_stall_quiet", {o_busy, o_valid, o_done}, 3'b000);

        // Reset mid-run during a stall, with a start in the same cycle.
        i_w = 6'd2; i_pm = 4'd1; i_tch = 4'd2; i_s = 4'd3; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        cyc(); cyc(); cyc();
        i_stall = 1'b1;
        cyc();
        rst = 1'b1; i_start = 1'b1; i_w = 6'd1; i_pm = 4'd1; i_tch = 4'd1; i_s = 4'd1;
        #1;
        chk("rst_during_quiet", {o_valid, o_busy, o_done, o_error}, 4'd0);
        cyc();
        rst = 1'b0; i_start = 1'b0; i_stall = 1'b0;
        #1;
        chk("rst_after_ctrl", {o_valid, o_first, o_last, o_busy, o_done, o_error}, 6'd0);
        chk("rst_after_addr", {o_ip_addr, o_wp_addr, o_pp_addr, o_stall_cnt}, 34'd0);
        cyc();
        chk("rst_start_ignored", {o_busy, o_valid}, 2'b00);
        cyc();
        chk("rst_start_ignored2", {o_busy, o_valid, o_error}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
